// File: rtl/soc_reset_sequencer_if.sv
// Board-side signal bundle of the SoC reset sequencer: button/switch/kick inputs
// and the reset, status and counter outputs toward the Murax SoC.
interface soc_reset_sequencer_if;
    logic       btn;
    logic       wdt_en;
    logic       wdt_kick;
    logic       soc_reset;
    logic       ready;
    logic       wdt_fired;
    logic [7:0] reset_count;

    // master is the sequencer itself; slave is the board top / SoC side.
    modport master (
        input  btn,
        input  wdt_en,
        input  wdt_kick,
        output soc_reset,
        output ready,
        output wdt_fired,
        output reset_count
    );

    modport slave (
        output btn,
        output wdt_en,
        output wdt_kick,
        input  soc_reset,
        input  ready,
        input  wdt_fired,
        input  reset_count
    );
endinterface

// File: rtl/soc_reset_sequencer.sv
// Reset sequencer for the Murax SoC: power-on stretch, debounced push-button reset
// and a kickable watchdog, all sharing one down-counter.
module soc_reset_sequencer #(
    parameter int unsigned POR_CYCLES      = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WDT_CYCLES      = 1048576,
    parameter int unsigned CNT_W           = 21
) (
    input  logic                         clk,
    input  logic                         rst_n,
    soc_reset_sequencer_if.master        bus,
    output logic [1:0]                   dbg_state
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LOAD = CNT_W'(WDT_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tc_q, tc_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_s_q, btn_s_d;
    logic              wdt_meta_q, wdt_meta_d;
    logic              wdt_en_s_q, wdt_en_s_d;
    logic              kick_prev_q, kick_prev_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              btn_db_q, btn_db_d;
    logic              soc_reset_q, soc_reset_d;
    logic              ready_q, ready_d;
    logic              wdt_fired_q, wdt_fired_d;
    logic [7:0]        reset_count_q, reset_count_d;

    logic              kick;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_dec;
    logic [7:0]        count_inc;

    assign kick      = bus.wdt_kick ^ kick_prev_q;
    assign cnt_zero  = (cnt_q == '0);
    assign cnt_dec   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    assign count_inc = (reset_count_q == 8'hFF) ? reset_count_q : reset_count_q + 8'd1;

    // Synchronizers, kick edge history and button debounce.
    always_comb begin
        btn_meta_d  = bus.btn;
        btn_s_d     = btn_meta_q;
        wdt_meta_d  = bus.wdt_en;
        wdt_en_s_d  = wdt_meta_q;
        kick_prev_d = bus.wdt_kick;
        db_cnt_d    = '0;
        btn_db_d    = btn_db_q;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // The zero detect is registered (tc_q) so the wide compare stays off the
    // state-register path; every counted window therefore spans N+1 edges.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tc_d          = 1'b0;
        wdt_fired_d   = wdt_fired_q;
        reset_count_d = reset_count_q;
        case (state_q)
            ST_POR: begin
                if (tc_q) begin
                    state_d = ST_RUN;
                    cnt_d   = WDT_LOAD;
                end else begin
                    cnt_d = cnt_dec;
                    tc_d  = cnt_zero;
                end
            end
            ST_RUN: begin
                // Button beats watchdog; expiry beats a same-cycle kick.
                if (btn_db_q) begin
                    state_d       = ST_HOLD;
                    reset_count_d = count_inc;
                end else if (wdt_en_s_q && tc_q) begin
                    state_d       = ST_HOLD;
                    wdt_fired_d   = 1'b1;
                    reset_count_d = count_inc;
                end else if (kick || !wdt_en_s_q) begin
                    cnt_d = WDT_LOAD;
                end else begin
                    cnt_d = cnt_dec;
                    tc_d  = cnt_zero;
                end
            end
            ST_HOLD: begin
                if (!btn_db_q) begin
                    state_d = ST_POR;
                    cnt_d   = POR_LOAD;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = POR_LOAD;
            end
        endcase
        ready_d     = (state_d == ST_RUN);
        soc_reset_d = !ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_POR;
            cnt_q         <= POR_LOAD;
            tc_q          <= 1'b0;
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            wdt_meta_q    <= 1'b0;
            wdt_en_s_q    <= 1'b0;
            kick_prev_q   <= 1'b0;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            soc_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
            wdt_fired_q   <= 1'b0;
            reset_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tc_q          <= tc_d;
            btn_meta_q    <= btn_meta_d;
            btn_s_q       <= btn_s_d;
            wdt_meta_q    <= wdt_meta_d;
            wdt_en_s_q    <= wdt_en_s_d;
            kick_prev_q   <= kick_prev_d;
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            soc_reset_q   <= soc_reset_d;
            ready_q       <= ready_d;
            wdt_fired_q   <= wdt_fired_d;
            reset_count_q <= reset_count_d;
        end
    end

    assign bus.soc_reset   = soc_reset_q;
    assign bus.ready       = ready_q;
    assign bus.wdt_fired   = wdt_fired_q;
    assign bus.reset_count = reset_count_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer with POR=8, DEBOUNCE=4, WDT=16.
module tb_soc_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  soc_reset_sequencer_if bus_if ();

  soc_reset_sequencer #(
    .POR_CYCLES      (8),
    .DEBOUNCE_CYCLES (4),
    .WDT_CYCLES      (16),
    .CNT_W           (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus_if.ready !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    check("wait_ready", {31'd0, bus_if.ready}, 32'd1);
  endtask

  initial begin
    bus_if.btn      = 1'b0;
    bus_if.wdt_en   = 1'b0;
    bus_if.wdt_kick = 1'b0;

    // reset values
    step(2);
    check("rst_soc_reset", {31'd0, bus_if.soc_reset}, 32'd1);
    check("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check("rst_wdt_fired", {31'd0, bus_if.wdt_fired}, 32'd0);
    check("rst_reset_count", {24'd0, bus_if.reset_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // power-on: 9 edges of reset after release
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("por_hold", {31'd0, bus_if.soc_reset}, 32'd1);
    end
    step(1);
    check("por_release", {31'd0, bus_if.soc_reset}, 32'd0);
    check("por_ready", {31'd0, bus_if.ready}, 32'd1);
    check("por_count", {24'd0, bus_if.reset_count}, 32'd0);

    // button bounce: toggle every 2 cycles, never stable long enough
    for (int i = 0; i < 10; i++) begin
      bus_if.btn = ~bus_if.btn;
      step(1);
      check("bounce_soc_reset", {31'd0, bus_if.soc_reset}, 32'd0);
      step(1);
      check("bounce_soc_reset", {31'd0, bus_if.soc_reset}, 32'd0);
    end
    step(4);
    check("bounce_settled", {31'd0, bus_if.soc_reset}, 32'd0);
    check("bounce_count", {24'd0, bus_if.reset_count}, 32'd0);

    // held press: reset exactly 7 edges after the rise
    bus_if.btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check("press_pending", {31'd0, bus_if.soc_reset}, 32'd0);
    end
    step(1);
    check("press_reset", {31'd0, bus_if.soc_reset}, 32'd1);
    check("press_ready", {31'd0, bus_if.ready}, 32'd0);
    check("press_count", {24'd0, bus_if.reset_count}, 32'd1);
    check("press_state_hold", {30'd0, dbg_state}, 32'd2);

    // release: 7 edges to leave HOLD plus 9 edges of POR
    step(3);
    bus_if.btn = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      check("release_hold", {31'd0, bus_if.soc_reset}, 32'd1);
    end
    step(1);
    check("release_run", {31'd0, bus_if.soc_reset}, 32'd0);
    check("release_count", {24'd0, bus_if.reset_count}, 32'd1);

    // watchdog fire: RUN entered at edge 9, expiry at edge 26, late kick ignored
    bus_if.wdt_en = 1'b1;
    pulse_reset();
    step(9);
    check("wdt_run_entry", {31'd0, bus_if.soc_reset}, 32'd0);
    for (int i = 10; i <= 25; i++) begin
      step(1);
      check("wdt_counting", {31'd0, bus_if.soc_reset}, 32'd0);
    end
    bus_if.wdt_kick = ~bus_if.wdt_kick;
    step(1);
    check("wdt_fire_reset", {31'd0, bus_if.soc_reset}, 32'd1);
    check("wdt_fire_flag", {31'd0, bus_if.wdt_fired}, 32'd1);
    check("wdt_fire_count", {24'd0, bus_if.reset_count}, 32'd1);
    for (int i = 27; i <= 35; i++) begin
      step(1);
      check("wdt_por_hold", {31'd0, bus_if.soc_reset}, 32'd1);
    end
    step(1);
    check("wdt_resume", {31'd0, bus_if.ready}, 32'd1);
    check("wdt_sticky", {31'd0, bus_if.wdt_fired}, 32'd1);
    bus_if.wdt_en = 1'b0;

    // watchdog kicked every 10 cycles: never fires
    bus_if.wdt_en = 1'b1;
    pulse_reset();
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (i % 10 == 0) bus_if.wdt_kick = ~bus_if.wdt_kick;
      if (i >= 9) check("kick_soc_reset", {31'd0, bus_if.soc_reset}, 32'd0);
    end
    check("kick_fired", {31'd0, bus_if.wdt_fired}, 32'd0);
    check("kick_count", {24'd0, bus_if.reset_count}, 32'd0);

    // collision: debounced button and expiry land on the same cycle (edge 26)
    pulse_reset();
    step(19);
    check("coll_run", {31'd0, bus_if.soc_reset}, 32'd0);
    bus_if.btn = 1'b1;
    step(6);
    check("coll_pending", {31'd0, bus_if.soc_reset}, 32'd0);
    step(1);
    check("coll_reset", {31'd0, bus_if.soc_reset}, 32'd1);
    check("coll_state_hold", {30'd0, dbg_state}, 32'd2);
    check("coll_fired", {31'd0, bus_if.wdt_fired}, 32'd0);
    check("coll_count", {24'd0, bus_if.reset_count}, 32'd1);
    bus_if.wdt_en = 1'b0;
    bus_if.btn    = 1'b0;

    // saturation: 260 more button resets
    for (int n = 0; n < 260; n++) begin
      wait_ready();
      bus_if.btn = 1'b1;
      step(8);
      bus_if.btn = 1'b0;
    end
    wait_ready();
    check("sat_count", {24'd0, bus_if.reset_count}, 32'd255);

    // asynchronous reset pulse in the middle of POR
    bus_if.btn = 1'b1;
    step(8);
    bus_if.btn = 1'b0;
    step(9);
    check("mid_por_state", {30'd0, dbg_state}, 32'd0);
    check("mid_por_count", {24'd0, bus_if.reset_count}, 32'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_soc_reset", {31'd0, bus_if.soc_reset}, 32'd1);
    check("async_ready", {31'd0, bus_if.ready}, 32'd0);
    check("async_fired", {31'd0, bus_if.wdt_fired}, 32'd0);
    check("async_count", {24'd0, bus_if.reset_count}, 32'd0);
    check("async_state", {30'd0, dbg_state}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_reset_sequencer.md
Name: soc_reset_sequencer

Overview:
Reset controller for the Murax SoC on the Basys3 board. Drives the SoC's active-high asynchronous reset input. It stretches a power-on reset, debounces a board push-button into a clean SoC reset, and runs a software-kicked watchdog that resets the SoC on timeout. It sits in the board top level between the BUFG'd 100 MHz clock, the button/switch pins and the Murax io_asyncReset and GPIO pins.

Parameters:
POR_CYCLES, 1024, cycles soc_reset is held after rst_n release and after every button/watchdog reset; must be >= 2.
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before the debounced button changes state; must be >= 1.
WDT_CYCLES, 1048576, idle cycles in RUN before the watchdog fires; must be >= 2.
CNT_W, 21, width of the shared down-counter; must be >= clog2 of the largest of the three cycle parameters.

Ports:
clk  input  1  100 MHz system clock (post-BUFG)
rst_n  input  1  asynchronous, active-low board reset
btn  input  1  raw push-button, active-high, asynchronous to clk
wdt_en  input  1  watchdog enable (board switch), asynchronous
wdt_kick  input  1  GPIO output bit from SoC; every level toggle is one kick
soc_reset  output  1  active-high reset to SoC io_asyncReset
ready  output  1  high while SoC is running (state RUN)
wdt_fired  output  1  sticky: a watchdog reset has occurred since rst_n
reset_count  output  8  number of button+watchdog resets, saturates at 255

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). All flops are cleared by rst_n.
- Values while rst_n is low: state=POR, counter=POR_CYCLES-1, soc_reset=1, ready=0, wdt_fired=0, reset_count=0. Synchronizers and debounced button=0. kick_prev=0.
- Synchronization: btn and wdt_en each pass through a 2-flop synchronizer. wdt_kick is same-domain and is not synchronized. kick = wdt_kick XOR kick_prev, where kick_prev is registered every cycle.
- Debounce: compare btn_s (synchronized) against the debounced value btn_d. On mismatch, a dedicated counter increments. Any match clears it. When the counter reaches DEBOUNCE_CYCLES-1 on a mismatch cycle, btn_d takes btn_s on the next edge and the counter clears.
- State machine (soc_reset and ready are registered decodes of the next state):
  - POR: soc_reset=1. The counter decrements each cycle. At 0, go to RUN and load the counter with WDT_CYCLES-1.
  - RUN: soc_reset=0, ready=1.
    - If btn_d=1: go to HOLD.
    - Else if wdt_en_s=1 and counter=0: go to HOLD and set wdt_fired.
    - Else if kick or wdt_en_s=0: reload the counter to WDT_CYCLES-1.
    - Else: decrement the counter.
  - HOLD: soc_reset=1. Stay while btn_d=1. When btn_d=0, go to POR and load the counter with POR_CYCLES-1.
- reset_count increments by one on each RUN->HOLD transition. It holds at 255.
- Priority: if btn_d=1 and a watchdog expiry occur in the same cycle, the button wins and wdt_fired is not set.
- A kick on the expiry cycle does not save it: expiry is evaluated before the kick reload.
- A button press during POR is ignored until RUN is reached. A press held across POR is then seen in the first RUN cycle, which goes to HOLD.
- wdt_en deasserting mid-count reloads the counter. Reasserting restarts a full WDT_CYCLES window.
- rst_n asserted at any time returns everything to the reset values immediately (asynchronous), regardless of state.
- Latency, rst_n release to soc_reset=0: POR_CYCLES+1 edges.
- Latency, btn rise to soc_reset=1: 2 (synchronizer) + DEBOUNCE_CYCLES + 1 (state) edges.

Test Plan (POR_CYCLES=8, DEBOUNCE_CYCLES=4, WDT_CYCLES=16):
- Power-on: release rst_n, btn=0, wdt_en=0. Required: soc_reset stays 1 for 9 edges, then 0. ready=1, reset_count=0.
- Button bounce: in RUN, toggle btn every 2 cycles for 20 cycles, then hold btn=0. Required: soc_reset stays 0 and reset_count=0. Then hold btn=1. Required: soc_reset=1 exactly 7 edges after the rise, reset_count=1. Release btn. Required: soc_reset returns to 0 after 2+4+1 edges to leave HOLD plus 9 edges of POR.
- Watchdog fire: wdt_en=1, no kicks. Required: soc_reset rises 17 cycles after the synchronized wdt_en enters RUN, wdt_fired=1, reset_count=1. After POR, RUN resumes with wdt_fired still 1.
- Watchdog kicked: wdt_en=1, toggle wdt_kick every 10 cycles for 200 cycles. Required: soc_reset stays 0, wdt_fired=0, reset_count=0.
- Collision: align the debounced btn assert with the cycle the counter reaches 0. Required: HOLD is entered, wdt_fired=0, reset_count increments by 1.
- Saturation and async reset: force 260 button resets. Required: reset_count=255. Then pulse rst_n low mid-POR. Required: all outputs return immediately to their reset values.
